// File: rtl/mem_stage.sv
// Memory-access / writeback stage: byte/half/word loads and stores over a
// req/ready + rvalid data-memory handshake, producing a registered writeback bundle.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2_data,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_funct3;
  logic        lat_reg_write;

  logic        accept;
  logic        is_mem;
  logic        acc_err;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;

  // Illegal encodings and misalignment are resolved at accept so no request is ever issued for them.
  always_comb begin
    acc_err = 1'b0;
    if (mem_read && mem_write) begin
      acc_err = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b011, 3'b110, 3'b111: acc_err = 1'b1;
        default:                acc_err = 1'b0;
      endcase
    end else if (mem_write) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: acc_err = 1'b0;
        default:                acc_err = 1'b1;
      endcase
    end
    if (is_mem && (funct3[1:0] == 2'b01) && alu_result[0]) begin
      acc_err = 1'b1;
    end
    if (is_mem && (funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
  end

  always_comb begin
    st_wdata = rs2_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_data[7:0]}};
        st_wstrb = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_data[15:0]}};
        st_wstrb = 4'b0011 << alu_result[1:0];
      end
      default: begin
        st_wdata = rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the latched address; the returned word is always the full aligned word.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lat_addr[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lat_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lat_addr      <= '0;
      lat_rd        <= '0;
      lat_funct3    <= '0;
      lat_reg_write <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr      <= alu_result;
            lat_rd        <= rd;
            lat_funct3    <= funct3;
            lat_reg_write <= reg_write;
            if (acc_err) begin
              wb_valid <= 1'b1;
              mem_err  <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= alu_result;
            end else if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= reg_write && (rd != 5'd0);
              wb_rd    <= rd;
              wb_data  <= alu_result;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              dmem_wdata <= mem_write ? st_wdata : 32'd0;
              dmem_wstrb <= mem_write ? st_wstrb : 4'd0;
            end
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= lat_rd;
              wb_data  <= lat_addr;
              state    <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= lat_reg_write && (lat_rd != 5'd0);
            wb_rd    <= lat_rd;
            wb_data  <= ld_data;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps plus randomized
// instructions compared against a byte-level behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd), .funct3(funct3),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: access size in bytes, lane offset, byte replication and arithmetic sign extension.
  task automatic refModel(input logic [2:0] f3, input logic [31:0] addr, rs2, rdata,
                          input logic [4:0] rd_i, input logic rw, mr, mw,
                          output logic is_err, output logic to_mem,
                          output logic [31:0] e_wdata, output logic [3:0] e_wstrb,
                          output logic [31:0] e_wb, output logic e_we);
    int size;
    int lane;
    bit legal;
    logic [63:0] v;
    logic [7:0]  m;
    size = 1 << f3[1:0];
    lane = int'(addr[1:0]);
    if (mr && mw) legal = 1'b0;
    else if (mr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else if (mw) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else legal = 1'b1;
    if (legal && (mr || mw) && (lane % size) != 0) legal = 1'b0;
    is_err = !legal;
    to_mem = legal && (mr || mw);
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
    m = ((8'd1 << size) - 8'd1) << lane;
    e_wstrb = mw ? m[3:0] : 4'd0;
    if (to_mem && mr) begin
      v = ({32'd0, rdata} >> (8*lane)) & ((64'd1 << (8*size)) - 64'd1);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8*size));
      e_wb = v[31:0];
    end else begin
      e_wb = addr;
    end
    e_we = legal && !mw && rw && (rd_i != 5'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input logic [4:0] rd_i, input logic rw, mr, mw,
                               input int ready_dly, input int rvalid_dly, input bit bogus);
    logic is_err, to_mem, e_we;
    logic [31:0] e_wdata, e_wb;
    logic [3:0]  e_wstrb;
    refModel(f3, addr, rs2, rdata, rd_i, rw, mr, mw, is_err, to_mem, e_wdata, e_wstrb, e_wb, e_we);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; funct3 = f3; alu_result = addr; rs2_data = rs2;
    rd = rd_i; reg_write = rw; mem_read = mr; mem_write = mw;
    tick();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (!to_mem) begin
      checkOutput({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({tag, ".mem_err"}, 32'(mem_err), 32'(is_err));
      checkOutput({tag, ".wb_we"}, 32'(wb_we), 32'(e_we));
      checkOutput({tag, ".wb_data"}, wb_data, e_wb);
      checkOutput({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd_i));
      checkOutput({tag, ".no_req"}, 32'(dmem_req), 32'd0);
    end else begin
      for (int c = 0; c <= ready_dly; c++) begin
        checkOutput({tag, ".req"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, ".we"}, 32'(dmem_we), 32'(mw));
        checkOutput({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        checkOutput({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(e_wstrb));
        if (mw) checkOutput({tag, ".wdata"}, dmem_wdata, e_wdata);
        checkOutput({tag, ".busy"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ".early_wb"}, 32'(wb_valid), 32'd0);
        dmem_ready  = (c == ready_dly);
        dmem_rvalid = bogus;
        dmem_rdata  = bogus ? ~rdata : 32'd0;
        tick();
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      if (mw) begin
        checkOutput({tag, ".st_wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, ".st_wb_we"}, 32'(wb_we), 32'd0);
        checkOutput({tag, ".st_wb_data"}, wb_data, addr);
        checkOutput({tag, ".st_err"}, 32'(mem_err), 32'd0);
        checkOutput({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
      end else begin
        for (int c = 0; c <= rvalid_dly; c++) begin
          checkOutput({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
          checkOutput({tag, ".wait_wb"}, 32'(wb_valid), 32'd0);
          checkOutput({tag, ".wait_busy"}, 32'(in_ready), 32'd0);
          dmem_rvalid = (c == rvalid_dly);
          dmem_rdata  = rdata;
          tick();
        end
        dmem_rvalid = 1'b0;
        checkOutput({tag, ".ld_wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, ".ld_wb_data"}, wb_data, e_wb);
        checkOutput({tag, ".ld_wb_we"}, 32'(wb_we), 32'(e_we));
        checkOutput({tag, ".ld_err"}, 32'(mem_err), 32'd0);
      end
      checkOutput({tag, ".mem_wb_rd"}, 32'(wb_rd), 32'(rd_i));
    end
    tick();
    checkOutput({tag, ".pulse_end"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, ".pulse_we"}, 32'(wb_we), 32'd0);
    checkOutput({tag, ".pulse_err"}, 32'(mem_err), 32'd0);
  endtask

  initial begin
    logic [31:0] raddr;
    logic [2:0]  rf3;
    int          op;

    reset = 1'b1; in_valid = 1'b0; alu_result = '0; rs2_data = '0; rd = '0;
    funct3 = '0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.req", 32'(dmem_req), 32'd0);
    checkOutput("rst.we", 32'(dmem_we), 32'd0);
    checkOutput("rst.addr", dmem_addr, 32'd0);
    checkOutput("rst.wdata", dmem_wdata, 32'd0);
    checkOutput("rst.wstrb", 32'(dmem_wstrb), 32'd0);
    checkOutput("rst.wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst.wb_we", 32'(wb_we), 32'd0);
    checkOutput("rst.wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst.wb_data", wb_data, 32'd0);
    checkOutput("rst.mem_err", 32'(mem_err), 32'd0);
    reset = 1'b0;

    // Back-to-back ALU ops retire one per cycle
    in_valid = 1'b1; rd = 5'd5; reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_result = 32'h1234_5678 + 32'(i);
      tick();
      checkOutput("alu.wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("alu.wb_data", wb_data, 32'h1234_5678 + 32'(i));
      checkOutput("alu.wb_we", 32'(wb_we), 32'd1);
      checkOutput("alu.in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("alu.drain", 32'(wb_valid), 32'd0);

    applyStimulus("sb", 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0);
    applyStimulus("lb", 3'b000, 32'h0000_2003, 32'd0, 32'h80FF_7F01, 5'd6, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus("lbu", 3'b100, 32'h0000_2003, 32'd0, 32'h80FF_7F01, 5'd6, 1'b1, 1'b1, 1'b0, 1, 2, 1'b0);
    applyStimulus("lh", 3'b001, 32'h0000_2002, 32'd0, 32'h80FF_7F01, 5'd7, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0);
    applyStimulus("lhu", 3'b101, 32'h0000_2000, 32'd0, 32'h80FF_7F01, 5'd8, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
    applyStimulus("lw", 3'b010, 32'h0000_2000, 32'd0, 32'h80FF_7F01, 5'd9, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus("lw_mis", 3'b010, 32'h0000_1002, 32'd0, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus("sh_mis", 3'b001, 32'h0000_1001, 32'h1234_5678, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    applyStimulus("ld_f3_011", 3'b011, 32'h0000_1000, 32'd0, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus("ld_rd0", 3'b010, 32'h0000_4000, 32'd0, 32'hCAFE_F00D, 5'd0, 1'b1, 1'b1, 1'b0, 2, 1, 1'b1);
    applyStimulus("sh_hi", 3'b001, 32'h0000_5002, 32'h0000_BEEF, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);

    // Reset while waiting for rvalid, then a late rvalid in IDLE
    in_valid = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_3000; rd = 5'd7;
    reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    tick();
    in_valid = 1'b0; mem_read = 1'b0; dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstw.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rstw.req", 32'(dmem_req), 32'd0);
    checkOutput("rstw.addr", dmem_addr, 32'd0);
    checkOutput("rstw.wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rstw.wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rstw.wb_data", wb_data, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("rstw.late_rvalid", 32'(wb_valid), 32'd0);
    checkOutput("rstw.idle", 32'(in_ready), 32'd1);
    applyStimulus("post_rst_alu", 3'b000, 32'h0BAD_F00D, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Randomized mix of ALU, load, store and conflicting ops
    for (int n = 0; n < 40; n++) begin
      op    = $urandom_range(0, 3);
      rf3   = 3'($urandom_range(0, 7));
      raddr = $urandom;
      if ($urandom_range(0, 1) == 0) raddr[1:0] = 2'b00;
      applyStimulus($sformatf("rnd%0d", n), rf3, raddr, $urandom, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    (op == 1 || op == 3), (op == 2 || op == 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
